// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle carrying one pipeline slot (data + control).
// Producers use the master modport, consumers the slave modport.
interface pipe_stage_reg_if #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 5
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage pipeline register with optional skid entry and flush.
// Control bits are gated off whenever the main entry holds a bubble.
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 5,
  parameter bit SKID   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [1:0]       occupancy
);

  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [1:0]        occupancy_r;

  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [1:0]        occupancy_s;

  logic              load_s;
  logic              in_ready_s;
  logic              in_fire_s;

  // Handshake qualifiers: with a skid entry in_ready depends only on state.
  always_comb begin
    load_s = !main_valid_r || dn.ready;
    if (SKID) begin
      in_ready_s = !skid_valid_r;
    end else begin
      in_ready_s = load_s;
    end
    in_fire_s = up.valid && in_ready_s;
  end

  // Next-state selection for main and skid entries; flush overrides all.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_ctrl_s  = main_ctrl_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_ctrl_s  = skid_ctrl_r;
    if (flush) begin
      main_valid_s = 1'b0;
      skid_valid_s = 1'b0;
    end else if (load_s) begin
      if (skid_valid_r) begin
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        main_ctrl_s  = skid_ctrl_r;
        skid_valid_s = 1'b0;
      end else if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = up.data;
        main_ctrl_s  = up.ctrl;
      end else begin
        main_valid_s = 1'b0;
      end
    end else begin
      // Main is stalled; only a skid build can still take the incoming slot.
      if (SKID && in_fire_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = up.data;
        skid_ctrl_s  = up.ctrl;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end
    occupancy_s = {1'b0, main_valid_s} + {1'b0, skid_valid_s};
  end

  // Storage registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= '0;
      main_ctrl_r  <= '0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_ctrl_r  <= '0;
      occupancy_r  <= 2'd0;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_ctrl_r  <= main_ctrl_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ctrl_r  <= skid_ctrl_s;
      occupancy_r  <= occupancy_s;
    end
  end

  assign up.ready  = in_ready_s;
  assign dn.valid  = main_valid_r;
  assign dn.data   = main_data_r;
  assign dn.ctrl   = main_ctrl_r & {CTRL_W{main_valid_r}};
  assign occupancy = occupancy_r;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance share stimulus and
// are each compared against a queue-based model of the held entries.
module tb_pipe_stage_reg;
  localparam int DW = 101;
  localparam int CW = 5;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_ready;
  logic [1:0]    occ1;
  logic [1:0]    occ0;

  int checks;
  int failures;

  ent_t          q1[$];
  ent_t          q0[$];
  logic [DW-1:0] obs1[$];

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) u1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) d1 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) u0 ();
  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) d0 ();

  assign u1.valid = in_valid;
  assign u1.data  = in_data;
  assign u1.ctrl  = in_ctrl;
  assign d1.ready = out_ready;
  assign u0.valid = in_valid;
  assign u0.data  = in_data;
  assign u0.ctrl  = in_ctrl;
  assign d0.ready = out_ready;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .up(u1.slave), .dn(d1.master), .occupancy(occ1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .up(u0.slave), .dn(d0.master), .occupancy(occ0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [DW-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] val(input int v);
    logic [DW-1:0] r;
    r = '0;
    r[31:0] = v;
    return r;
  endfunction

  // Advance one clock; record observed deliveries and update both models.
  task automatic tick();
    ent_t e;
    bit   f1, f0, o1, o0;
    @(negedge clk);
    if (d1.valid && out_ready) obs1.push_back(d1.data);
    @(posedge clk);
    e.d = in_data;
    e.c = in_ctrl;
    f1 = in_valid && (q1.size() < 2);
    o1 = (q1.size() != 0) && out_ready;
    f0 = in_valid && ((q0.size() == 0) || out_ready);
    o0 = (q0.size() != 0) && out_ready;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (o1) void'(q1.pop_front());
      if (f1) q1.push_back(e);
      if (o0) void'(q0.pop_front());
      if (f0) q0.push_back(e);
    end
    #1;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    #2;
    checks++; if (d1.valid !== 1'b0) begin failures++; $display("FAIL reset_valid1 got=%b exp=0", d1.valid); end
    checks++; if (d1.ctrl !== 5'd0) begin failures++; $display("FAIL reset_ctrl1 got=%b exp=0", d1.ctrl); end
    checks++; if (d1.data !== '0) begin failures++; $display("FAIL reset_data1 got=%h exp=0", d1.data); end
    checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
    checks++; if (u1.ready !== 1'b1) begin failures++; $display("FAIL reset_ready1 got=%b exp=1", u1.ready); end
    checks++; if (u0.ready !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", u0.ready); end
    checks++; if (occ0 !== 2'd0) begin failures++; $display("FAIL reset_occ0 got=%0d exp=0", occ0); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    tick();
    checks++; if (d1.valid !== 1'b0 || occ1 !== 2'd0) begin failures++; $display("FAIL post_reset_idle1 got=%b/%0d exp=0/0", d1.valid, occ1); end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] exp;
    out_ready = 1'b1;
    in_ctrl   = 5'b10011;
    #1;
    checks++; if (d1.valid !== 1'b0) begin failures++; $display("FAIL stream_pre_valid got=%b exp=0", d1.valid); end
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = val(32'h10 + i);
      #1;
      checks++; if (u1.ready !== 1'b1) begin failures++; $display("FAIL stream_ready1 i=%0d got=%b exp=1", i, u1.ready); end
      tick();
      exp = val(32'h10 + i);
      checks++; if (d1.valid !== 1'b1 || d1.data !== exp) begin failures++; $display("FAIL stream_out1 i=%0d got=%b/%h exp=1/%h", i, d1.valid, d1.data, exp); end
      checks++; if (d1.ctrl !== 5'b10011) begin failures++; $display("FAIL stream_ctrl1 i=%0d got=%b exp=10011", i, d1.ctrl); end
      checks++; if (d0.data !== exp) begin failures++; $display("FAIL stream_out0 i=%0d got=%h exp=%h", i, d0.data, exp); end
    end
    drain();
  endtask

  task automatic test_backpressure();
    obs1.delete();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 5'b00101;
    in_data = val(32'hA);
    tick();
    out_ready = 1'b0;
    in_data = val(32'hB);
    #1;
    checks++; if (u1.ready !== 1'b1 || occ1 !== 2'd1) begin failures++; $display("FAIL bp_absorb got=%b/%0d exp=1/1", u1.ready, occ1); end
    tick();
    in_data = val(32'hC);
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL bp_occ k=%0d got=%0d exp=2", k, occ1); end
      checks++; if (u1.ready !== 1'b0) begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0", k, u1.ready); end
      checks++; if (d1.data !== val(32'hA)) begin failures++; $display("FAIL bp_hold k=%0d got=%h exp=a", k, d1.data); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    checks++; if (d1.data !== val(32'hB) || occ1 !== 2'd1 || u1.ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%h/%0d/%b exp=b/1/1", d1.data, occ1, u1.ready); end
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (obs1.size() != 3) begin failures++; $display("FAIL bp_count got=%0d exp=3", obs1.size()); end
    else begin
      checks++; if (obs1[0] !== val(32'hA) || obs1[1] !== val(32'hB) || obs1[2] !== val(32'hC)) begin failures++; $display("FAIL bp_order got=%h,%h,%h exp=a,b,c", obs1[0], obs1[1], obs1[2]); end
    end
    drain();
  endtask

  task automatic test_bubble();
    in_valid = 1'b0;
    in_ctrl  = 5'b11111;
    for (int k = 0; k < 4; k++) begin
      in_data   = rnd_data();
      out_ready = 1'($urandom_range(0, 1));
      tick();
      checks++; if (d1.valid !== 1'b0 || d1.ctrl !== 5'd0) begin failures++; $display("FAIL bubble1 k=%0d got=%b/%b exp=0/0", k, d1.valid, d1.ctrl); end
      checks++; if (d0.valid !== 1'b0 || d0.ctrl !== 5'd0) begin failures++; $display("FAIL bubble0 k=%0d got=%b/%b exp=0/0", k, d0.valid, d0.ctrl); end
    end
  endtask

  task automatic test_flush();
    obs1.delete();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'b01010;
    in_data = val(32'h1);
    tick();
    in_data = val(32'h2);
    tick();
    checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occ1); end
    in_data = val(32'hD);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (occ1 !== 2'd0 || d1.valid !== 1'b0 || u1.ready !== 1'b1) begin failures++; $display("FAIL flush_clear1 got=%0d/%b/%b exp=0/0/1", occ1, d1.valid, u1.ready); end
    checks++; if (d1.ctrl !== 5'd0) begin failures++; $display("FAIL flush_ctrl1 got=%b exp=0", d1.ctrl); end
    checks++; if (occ0 !== 2'd0 || d0.valid !== 1'b0 || u0.ready !== 1'b1) begin failures++; $display("FAIL flush_clear0 got=%0d/%b/%b exp=0/0/1", occ0, d0.valid, u0.ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    checks++; if (obs1.size() != 0) begin failures++; $display("FAIL flush_leak got=%0d entries exp=0", obs1.size()); end
  endtask

  task automatic test_noskid();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 5'b00001;
    in_data = val(32'h20);
    tick();
    out_ready = 1'b0;
    #1;
    checks++; if (u0.ready !== 1'b0 || occ0 !== 2'd1) begin failures++; $display("FAIL noskid_stall got=%b/%0d exp=0/1", u0.ready, occ0); end
    out_ready = 1'b1;
    #1;
    checks++; if (u0.ready !== 1'b1) begin failures++; $display("FAIL noskid_comb_ready got=%b exp=1", u0.ready); end
    for (int i = 1; i < 5; i++) begin
      in_data = val(32'h20 + i);
      tick();
      checks++; if (d0.valid !== 1'b1 || d0.data !== val(32'h20 + i) || occ0 !== 2'd1) begin failures++; $display("FAIL noskid_stream i=%0d got=%b/%h/%0d exp=1/%0h/1", i, d0.valid, d0.data, occ0, 32'h20 + i); end
    end
    drain();
  endtask

  task automatic test_random();
    logic [CW-1:0] ec1, ec0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = rnd_data();
      in_ctrl   = CW'($urandom());
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 31) == 0);
      #1;
      ec1 = (q1.size() != 0) ? q1[0].c : '0;
      ec0 = (q0.size() != 0) ? q0[0].c : '0;
      checks++; if (d1.valid !== (q1.size() != 0)) begin failures++; $display("FAIL rnd_valid1 cyc=%0d got=%b exp=%b", cyc, d1.valid, q1.size() != 0); end
      checks++; if (d1.ctrl !== ec1) begin failures++; $display("FAIL rnd_ctrl1 cyc=%0d got=%b exp=%b", cyc, d1.ctrl, ec1); end
      checks++; if (occ1 !== 2'(q1.size())) begin failures++; $display("FAIL rnd_occ1 cyc=%0d got=%0d exp=%0d", cyc, occ1, q1.size()); end
      checks++; if (u1.ready !== (q1.size() < 2)) begin failures++; $display("FAIL rnd_ready1 cyc=%0d got=%b exp=%b", cyc, u1.ready, q1.size() < 2); end
      if (q1.size() != 0) begin
        checks++; if (d1.data !== q1[0].d) begin failures++; $display("FAIL rnd_data1 cyc=%0d got=%h exp=%h", cyc, d1.data, q1[0].d); end
      end
      checks++; if (d0.valid !== (q0.size() != 0)) begin failures++; $display("FAIL rnd_valid0 cyc=%0d got=%b exp=%b", cyc, d0.valid, q0.size() != 0); end
      checks++; if (d0.ctrl !== ec0) begin failures++; $display("FAIL rnd_ctrl0 cyc=%0d got=%b exp=%b", cyc, d0.ctrl, ec0); end
      checks++; if (occ0 !== 2'(q0.size())) begin failures++; $display("FAIL rnd_occ0 cyc=%0d got=%0d exp=%0d", cyc, occ0, q0.size()); end
      checks++; if (u0.ready !== ((q0.size() == 0) || out_ready)) begin failures++; $display("FAIL rnd_ready0 cyc=%0d got=%b exp=%b", cyc, u0.ready, (q0.size() == 0) || out_ready); end
      if (q0.size() != 0) begin
        checks++; if (d0.data !== q0[0].d) begin failures++; $display("FAIL rnd_data0 cyc=%0d got=%h exp=%h", cyc, d0.data, q0[0].d); end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'b11011;
    in_data = val(32'h31);
    tick();
    in_data = val(32'h32);
    tick();
    in_valid = 1'b0;
    checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL areset_pre_occ got=%0d exp=2", occ1); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (d1.valid !== 1'b0 || d1.ctrl !== 5'd0 || d1.data !== '0) begin failures++; $display("FAIL areset_out1 got=%b/%b/%h exp=0/0/0", d1.valid, d1.ctrl, d1.data); end
    checks++; if (occ1 !== 2'd0 || u1.ready !== 1'b1) begin failures++; $display("FAIL areset_occ_ready1 got=%0d/%b exp=0/1", occ1, u1.ready); end
    checks++; if (d0.valid !== 1'b0 || occ0 !== 2'd0 || u0.ready !== 1'b1) begin failures++; $display("FAIL areset_dut0 got=%b/%0d/%b exp=0/0/1", d0.valid, occ0, u0.ready); end
    q1.delete();
    q0.delete();
    #2;
    reset = 1'b0;
    tick();
    checks++; if (occ1 !== 2'd0 || u1.ready !== 1'b1) begin failures++; $display("FAIL areset_after got=%0d/%b exp=0/1", occ1, u1.ready); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_flush();
    test_noskid();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic inter-stage pipeline register for the processor datapath (EX/MEM, MEM/WB and similar boundaries). It carries a data bundle and a control bundle with a valid/ready handshake and a synchronous flush. An optional skid entry lets the upstream ready be a pure register output. Control bits are forced to zero whenever the stage holds a bubble, so downstream write enables never fire on invalid slots.

## Interface
- DATA_W, 101, width of data bundle (e.g. ALU result 32 + store data 32 + PC+4 32 + dest reg 5)
- CTRL_W, 5, width of control bundle (e.g. RegWrite, MemtoReg[1:0], MemRead, MemWrite)
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- clk  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream slot holds a real instruction
- in_ready  out  1  stage can accept this cycle
- in_data  in  DATA_W  upstream data bundle
- in_ctrl  in  CTRL_W  upstream control bundle
- flush  in  1  synchronous kill of all held and incoming entries
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts this cycle
- out_data  out  DATA_W  main entry data
- out_ctrl  out  CTRL_W  main entry control, zero when out_valid=0
- occupancy  out  2  entries held (0..2; max 1 when SKID=0)

## Operation
- Storage: main entry (main_valid, main_data, main_ctrl); with SKID=1 also a skid entry (skid_valid, skid_data, skid_ctrl).
- Accept: in_fire = in_valid & in_ready. Deliver: out_fire = out_valid & out_ready.
- in_ready: SKID=1 -> !skid_valid (register output, no combinational path from out_ready). SKID=0 -> !main_valid | out_ready.
- Main load condition: !main_valid | out_ready.
  - If load and skid_valid: main <= skid, skid cleared.
  - Else if load and in_fire: main <= in.
  - Else if load: main_valid <= 0.
  - If no load (main stalled) and in_fire: skid <= in (SKID=1 only; SKID=0 cannot accept here).
- Flush has priority over everything: main_valid <= 0, skid_valid <= 0, any in_fire in that cycle is discarded, any out_fire in that cycle still counts as delivered downstream.
- out_ctrl = main_ctrl AND replicated main_valid; out_data is the held main_data (not gated).
- occupancy = main_valid + skid_valid.
- Order is strictly FIFO; no entry is ever duplicated or dropped except by flush.

## Timing
- Reset (async assert, sync-released state): main_valid=0, skid_valid=0, all data/ctrl registers 0; hence out_valid=0, out_ctrl=0, out_data=0, occupancy=0, in_ready=1.
- Latency: in_fire at edge N -> out_valid=1 with that data after edge N (visible cycle N+1).
- Throughput: 1 entry/cycle sustained while out_ready=1; no bubbles inserted.
- Backpressure (SKID=1): out_ready drops with main full -> one more input is absorbed into skid; in_ready goes 0 the cycle after. When out_ready returns, skid moves to main on that edge; in_ready=1 the following cycle.
- Simultaneous skid drain and in_valid: impossible by construction (in_ready=0 while skid_valid).
- Flush with out_ready=0 and both entries full: all cleared after one edge; occupancy=0, in_ready=1 next cycle.
- Reset mid-stall: all entries discarded immediately, outputs return to reset values without waiting for a clock.

## Test plan
- Streaming: SKID=1, out_ready=1, push data 0x10..0x17 with ctrl=5'b10011 back-to-back -> out_data 0x10..0x17 on consecutive cycles, 1-cycle latency, in_ready constantly 1.
- Backpressure: push 0xA,0xB,0xC continuously, out_ready=0 from cycle of 0xA output -> 0xA held, 0xB in skid, occupancy=2, in_ready=0, 0xC held upstream; release -> 0xA,0xB,0xC delivered in order, none lost.
- Bubble gating: in_valid=0 with in_ctrl=5'b11111 -> out_valid=0, out_ctrl=0 every cycle.
- Flush: occupancy=2, in_valid=1 with 0xD, flush=1 for one cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; 0xD never appears at output.
- SKID=0 build: main full, out_ready=0 -> in_ready=0 combinationally; out_ready=1 with in_valid=1 -> replacement in same edge, full throughput.
- Async reset: assert reset mid-cycle with occupancy=2 -> out_valid, out_ctrl, out_data, occupancy go 0 before next edge; in_ready=1.
